// File: rtl/vector_accumulator_pkg.sv
// Shared definitions for the lane-wise vector accumulator.
//   - Default geometry (lanes, lane width, beat limit)
//   - FSM state encoding
package vacc_pkg;

  localparam int VACC_LANES     = 8;
  localparam int VACC_WIDTH     = 32;
  localparam int VACC_MAX_BEATS = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } vacc_state_t;

endpackage

// File: rtl/vector_accumulator_if.sv
// Handshake bundle between the multiplier, the accumulator and the consumer.
//   in_*  : valid/ready input stream of LANES*WIDTH scaled vectors
//   out_* : valid/ready result channel (sum, per-lane overflow, beat count, trunc)
// Modports:
//   slave  : accumulator side (consumes in_*, produces out_*)
//   master : environment side (produces in_*, consumes out_*)
interface vector_accumulator_if
  import vacc_pkg::*;
#(
  parameter int LANES     = VACC_LANES,
  parameter int WIDTH     = VACC_WIDTH,
  parameter int MAX_BEATS = VACC_MAX_BEATS
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_vector;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_vector;
  logic [LANES-1:0]       out_ovf;
  logic [CW-1:0]          out_count;
  logic                   out_trunc;

  modport slave (
    input  in_valid, in_vector, in_last, out_ready,
    output in_ready, out_valid, out_vector, out_ovf, out_count, out_trunc
  );

  modport master (
    output in_valid, in_vector, in_last, out_ready,
    input  in_ready, out_valid, out_vector, out_ovf, out_count, out_trunc
  );
endinterface

// File: rtl/vector_accumulator_lane.sv
// One accumulator lane: WIDTH-bit wrapping adder with a sticky signed-overflow flag.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en_i       : a beat is accepted this cycle
//   load_i     : first beat of an accumulation (load instead of add, clear overflow)
//   lane_i     : this lane's slice of the incoming vector
//   acc_o      : registered running sum
//   ovf_o      : registered sticky overflow flag
module vacc_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] lane_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             ovf_o
);

  // Signed overflow: operands share a sign and the wrapped sum does not.
  function automatic logic add_ovf(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic [WIDTH-1:0] acc_q, acc_d, sum_s;
  logic             ovf_q, ovf_d;

  // Next-state for the running sum and overflow flag.
  always_comb begin
    sum_s = acc_q + lane_i;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (en_i) begin
      if (load_i) begin
        acc_d = lane_i;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum_s;
        ovf_d = ovf_q | add_ovf(acc_q, lane_i, sum_s);
      end
    end else begin
      acc_d = acc_q;
      ovf_d = ovf_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {WIDTH{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/vector_accumulator.sv
// Lane-wise vector accumulator (channel-reduction stage).
// Sums a stream of LANES x WIDTH vectors per lane modulo 2^WIDTH until in_last or
// MAX_BEATS beats, then holds the result with overflow flags and beat count until
// the consumer takes it.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of vector_accumulator_if (input stream + result channel)
module vector_accumulator
  import vacc_pkg::*;
#(
  parameter int LANES     = VACC_LANES,
  parameter int WIDTH     = VACC_WIDTH,
  parameter int MAX_BEATS = VACC_MAX_BEATS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_accumulator_if.slave  bus
);

  localparam int            CW    = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BEATS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  vacc_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_next_s;
  logic          trunc_q, trunc_d;
  logic          in_ready_s, accept_s, load_s, limit_s, term_s;
  logic [LANES*WIDTH-1:0] acc_s;
  logic [LANES-1:0]       ovf_s;

  // A new accumulation starts on any beat accepted outside ACCUM; in HOLD a
  // beat can only be accepted alongside out_ready, so the result is consumed.
  assign in_ready_s = (state_q != HOLD) || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign load_s     = (state_q != ACCUM);

  // FSM next state, beat counter and truncation flag.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    trunc_d      = trunc_q;
    count_next_s = load_s ? ONE_C : (count_q + ONE_C);
    limit_s      = (count_next_s == MAX_C);
    term_s       = bus.in_last || limit_s;
    if (accept_s) begin
      count_d = count_next_s;
      trunc_d = limit_s && !bus.in_last;
      state_d = term_s ? HOLD : ACCUM;
    end else begin
      case (state_q)
        HOLD: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= {CW{1'b0}};
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vacc_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (accept_s),
      .load_i (load_s),
      .lane_i (bus.in_vector[g*WIDTH +: WIDTH]),
      .acc_o  (acc_s[g*WIDTH +: WIDTH]),
      .ovf_o  (ovf_s[g])
    );
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_vector = acc_s;
  assign bus.out_ovf    = ovf_s;
  assign bus.out_count  = count_q;
  assign bus.out_trunc  = trunc_q;

endmodule

// File: tb/tb_vector_accumulator.sv
module tb_vector_accumulator;
  localparam int L  = 8;
  localparam int W  = 32;
  localparam int MB = 256;

  typedef logic [L*W-1:0] vec_t;
  typedef struct {
    vec_t       vec;
    logic [L-1:0] ovf;
    int         count;
    logic       trunc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vector_accumulator_if #(.LANES(L), .WIDTH(W), .MAX_BEATS(MB)) dif ();
  vector_accumulator_if #(.LANES(2), .WIDTH(16), .MAX_BEATS(4)) m4if ();
  vector_accumulator_if #(.LANES(2), .WIDTH(8), .MAX_BEATS(1))  m1if ();

  vector_accumulator #(.LANES(L), .WIDTH(W), .MAX_BEATS(MB)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(dif));
  vector_accumulator #(.LANES(2), .WIDTH(16), .MAX_BEATS(4)) u_m4 (
    .clk(clk), .rst_n(rst_n), .bus(m4if));
  vector_accumulator #(.LANES(2), .WIDTH(8), .MAX_BEATS(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .bus(m1if));

  int n_checks = 0;
  int n_fail   = 0;
  vec_t beats_q[$];
  res_t exp_q[$];
  vec_t scaled;

  // Reference: sum the beats lane by lane with wide signed arithmetic.
  function automatic res_t reduce_beats(input logic last);
    res_t r;
    r.vec   = '0;
    r.ovf   = '0;
    r.count = beats_q.size();
    r.trunc = !last;
    for (int i = 0; i < L; i++) begin
      vec_t b = beats_q[0];
      logic [W-1:0] acc = b[i*W +: W];
      for (int k = 1; k < beats_q.size(); k++) begin
        longint t;
        b = beats_q[k];
        t = longint'($signed(acc)) + longint'($signed(b[i*W +: W]));
        if (t > 64'sd2147483647 || t < -64'sd2147483648) r.ovf[i] = 1'b1;
        acc = t[W-1:0];
      end
      r.vec[i*W +: W] = acc;
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < L; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_d(input vec_t v, input logic last);
    dif.in_valid  = 1'b1;
    dif.in_vector = v;
    dif.in_last   = last;
    tick();
    dif.in_valid  = 1'b0;
    dif.in_last   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if (dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", dif.in_ready); end
    n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", dif.out_valid); end
    n_checks++; if (dif.out_vector !== '0) begin n_fail++; $display("FAIL reset_out_vector: got %h want 0", dif.out_vector); end
    n_checks++; if (dif.out_ovf !== 8'h00 || dif.out_count !== 9'd0 || dif.out_trunc !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ovf=%h cnt=%0d tr=%b want 0/0/0", dif.out_ovf, dif.out_count, dif.out_trunc); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    dif.out_ready = 1'b0;
    beat_d(scaled, 1'b1);
    n_checks++; if (dif.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", dif.out_valid); end
    n_checks++; if (dif.out_vector[31:0] !== 32'h56677880) begin n_fail++; $display("FAIL single_lane0: got %h want 56677880", dif.out_vector[31:0]); end
    n_checks++; if (dif.out_vector !== scaled) begin n_fail++; $display("FAIL single_vec: got %h want %h", dif.out_vector, scaled); end
    n_checks++; if (dif.out_count !== 9'd1 || dif.out_ovf !== 8'h00 || dif.out_trunc !== 1'b0) begin
      n_fail++; $display("FAIL single_flags: got cnt=%0d ovf=%h tr=%b want 1/00/0", dif.out_count, dif.out_ovf, dif.out_trunc); end
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
    n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", dif.out_valid); end
  endtask

  task automatic test_double(output res_t r);
    beat_d(scaled, 1'b0);
    n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL double_mid_valid: got %b want 0", dif.out_valid); end
    beat_d(scaled, 1'b1);
    n_checks++; if (dif.out_vector[31:0] !== 32'hACCEF100 || dif.out_ovf[0] !== 1'b1) begin
      n_fail++; $display("FAIL double_lane0: got %h ovf=%b want accef100 ovf=1", dif.out_vector[31:0], dif.out_ovf[0]); end
    n_checks++; if (dif.out_vector[127:96] !== 32'h24466880 || dif.out_ovf[3] !== 1'b0) begin
      n_fail++; $display("FAIL double_lane3: got %h ovf=%b want 24466880 ovf=0", dif.out_vector[127:96], dif.out_ovf[3]); end
    n_checks++; if (dif.out_vector[95:64] !== 32'h310EECC0 || dif.out_ovf[2] !== 1'b1) begin
      n_fail++; $display("FAIL double_lane2: got %h ovf=%b want 310eecc0 ovf=1", dif.out_vector[95:64], dif.out_ovf[2]); end
    n_checks++; if (dif.out_count !== 9'd2) begin n_fail++; $display("FAIL double_count: got %0d want 2", dif.out_count); end
    beats_q.delete();
    beats_q.push_back(scaled);
    beats_q.push_back(scaled);
    r = reduce_beats(1'b1);
    beats_q.delete();
    n_checks++; if (dif.out_vector !== r.vec || dif.out_ovf !== r.ovf) begin
      n_fail++; $display("FAIL double_model: got %h/%h want %h/%h", dif.out_vector, dif.out_ovf, r.vec, r.ovf); end
  endtask

  task automatic test_hold_stall(input res_t r);
    vec_t nv;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_handshake c%0d: got rdy=%b vld=%b want 0/1", c, dif.in_ready, dif.out_valid); end
      n_checks++; if (dif.out_vector !== r.vec || dif.out_count !== 9'd2) begin
        n_fail++; $display("FAIL hold_stable c%0d: got %h cnt=%0d want %h cnt=2", c, dif.out_vector, dif.out_count, r.vec); end
    end
    nv = rand_vec();
    dif.out_ready = 1'b1;
    beat_d(nv, 1'b1);
    n_checks++; if (dif.out_valid !== 1'b1 || dif.out_vector !== nv || dif.out_count !== 9'd1) begin
      n_fail++; $display("FAIL hold_b2b: got vld=%b %h cnt=%0d want 1 %h cnt=1", dif.out_valid, dif.out_vector, dif.out_count, nv); end
    tick();
    dif.out_ready = 1'b0;
    n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drain: got %b want 0", dif.out_valid); end
  endtask

  task automatic test_max4();
    m4if.out_ready = 1'b1;
    m4if.in_valid  = 1'b1;
    m4if.in_vector = 32'h0001_0001;
    m4if.in_last   = 1'b0;
    for (int b = 0; b < 4; b++) tick();
    n_checks++; if (m4if.out_valid !== 1'b1 || m4if.out_vector !== 32'h0004_0004) begin
      n_fail++; $display("FAIL max4_sum: got vld=%b %h want 1 00040004", m4if.out_valid, m4if.out_vector); end
    n_checks++; if (m4if.out_count !== 3'd4 || m4if.out_trunc !== 1'b1) begin
      n_fail++; $display("FAIL max4_trunc: got cnt=%0d tr=%b want 4/1", m4if.out_count, m4if.out_trunc); end
    tick();
    n_checks++; if (m4if.out_valid !== 1'b0 || m4if.out_count !== 3'd1) begin
      n_fail++; $display("FAIL max4_fifth: got vld=%b cnt=%0d want 0/1", m4if.out_valid, m4if.out_count); end
    m4if.in_last = 1'b1;
    tick();
    n_checks++; if (m4if.out_vector !== 32'h0002_0002 || m4if.out_count !== 3'd2 || m4if.out_trunc !== 1'b0) begin
      n_fail++; $display("FAIL max4_second: got %h cnt=%0d tr=%b want 00020002/2/0", m4if.out_vector, m4if.out_count, m4if.out_trunc); end
    m4if.in_valid = 1'b0;
    m4if.in_last  = 1'b0;
    tick();
    m4if.in_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m4if.in_last = (b == 3);
      tick();
    end
    m4if.in_valid = 1'b0;
    m4if.in_last  = 1'b0;
    n_checks++; if (m4if.out_valid !== 1'b1 || m4if.out_count !== 3'd4 || m4if.out_trunc !== 1'b0) begin
      n_fail++; $display("FAIL max4_last_and_limit: got vld=%b cnt=%0d tr=%b want 1/4/0", m4if.out_valid, m4if.out_count, m4if.out_trunc); end
    tick();
    m4if.out_ready = 1'b0;
  endtask

  task automatic test_max1();
    m1if.out_ready = 1'b1;
    m1if.in_valid  = 1'b1;
    m1if.in_vector = 16'h0503;
    m1if.in_last   = 1'b0;
    tick();
    n_checks++; if (m1if.out_valid !== 1'b1 || m1if.out_vector !== 16'h0503 || m1if.out_count !== 1'd1 || m1if.out_trunc !== 1'b1) begin
      n_fail++; $display("FAIL max1_trunc: got vld=%b %h cnt=%0d tr=%b want 1 0503 1 1", m1if.out_valid, m1if.out_vector, m1if.out_count, m1if.out_trunc); end
    m1if.in_vector = 16'h7F01;
    m1if.in_last   = 1'b1;
    tick();
    n_checks++; if (m1if.out_valid !== 1'b1 || m1if.out_vector !== 16'h7F01 || m1if.out_trunc !== 1'b0) begin
      n_fail++; $display("FAIL max1_last: got vld=%b %h tr=%b want 1 7f01 0", m1if.out_valid, m1if.out_vector, m1if.out_trunc); end
    m1if.in_valid = 1'b0;
    m1if.in_last  = 1'b0;
    tick();
    m1if.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    vec_t rv;
    for (int b = 0; b < 3; b++) beat_d(rand_vec(), 1'b0);
    n_checks++; if (dif.out_count !== 9'd3 || dif.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_pre: got cnt=%0d vld=%b want 3/0", dif.out_count, dif.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (dif.out_count !== 9'd0 || dif.out_vector !== '0 || dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_now: got cnt=%0d vec=%h rdy=%b vld=%b want 0/0/1/0", dif.out_count, dif.out_vector, dif.in_ready, dif.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rv = rand_vec();
    beat_d(rv, 1'b1);
    n_checks++; if (dif.out_count !== 9'd1 || dif.out_vector !== rv || dif.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_after: got cnt=%0d %h vld=%b want 1 %h 1", dif.out_count, dif.out_vector, dif.out_valid, rv); end
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
  endtask

  task automatic test_random();
    localparam int N = 600;
    res_t r;
    beats_q.delete();
    exp_q.delete();
    for (int c = 0; c < N + 8; c++) begin
      if (c < N) begin
        dif.in_valid  = ($urandom_range(0, 9) < 7);
        dif.in_last   = ($urandom_range(0, 5) == 0);
        dif.out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        dif.in_valid  = (c == N);
        dif.in_last   = 1'b1;
        dif.out_ready = 1'b1;
      end
      dif.in_vector = rand_vec();
      #1;
      if (dif.out_valid && dif.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected c%0d: got result %h want none", c, dif.out_vector);
        end else begin
          r = exp_q.pop_front();
          if (dif.out_vector !== r.vec || dif.out_ovf !== r.ovf || int'(dif.out_count) != r.count || dif.out_trunc !== r.trunc) begin
            n_fail++;
            $display("FAIL rand_result c%0d: got %h ovf=%h cnt=%0d tr=%b want %h ovf=%h cnt=%0d tr=%b", c,
                     dif.out_vector, dif.out_ovf, dif.out_count, dif.out_trunc, r.vec, r.ovf, r.count, r.trunc);
          end
        end
      end
      if (dif.in_valid && dif.in_ready) begin
        beats_q.push_back(dif.in_vector);
        if (dif.in_last || beats_q.size() == MB) begin
          exp_q.push_back(reduce_beats(dif.in_last));
          beats_q.delete();
        end
      end
      @(posedge clk);
      #1;
    end
    dif.in_valid  = 1'b0;
    dif.in_last   = 1'b0;
    dif.out_ready = 1'b0;
    n_checks++; if (exp_q.size() != 0 || beats_q.size() != 0) begin
      n_fail++; $display("FAIL rand_leftover: got %0d results %0d beats pending want 0/0", exp_q.size(), beats_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r2;
    logic [31:0] raw [8];
    raw = '{32'h56839f3a, 32'h5d3bb349, 32'h01d3a5b1, 32'he5780056,
            32'h11223344, 32'h99887766, 32'h44556677, 32'h55667788};
    for (int i = 0; i < L; i++) scaled[i*W +: W] = raw[L-1-i] * 32'h10;
    dif.in_valid = 1'b0;  dif.in_last = 1'b0;  dif.in_vector = '0;  dif.out_ready = 1'b0;
    m4if.in_valid = 1'b0; m4if.in_last = 1'b0; m4if.in_vector = '0; m4if.out_ready = 1'b0;
    m1if.in_valid = 1'b0; m1if.in_last = 1'b0; m1if.in_vector = '0; m1if.out_ready = 1'b0;
    test_reset();
    test_single();
    test_double(r2);
    test_hold_stall(r2);
    test_max4();
    test_max1();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
